// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard controller.
//   state_e        : stall FSM encoding (RUN, MISS_STALL, MISS_DRAIN)
//   FWD_*          : forwarding select encodings used by op1/op2/csr selects
//   DEFAULT_CNT_W  : default width of the performance counters
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        MISS_STALL = 2'd1,
        MISS_DRAIN = 2'd2
    } state_e;

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_MEM = 2'd1;
    localparam logic [1:0] FWD_WB  = 2'd2;

    localparam int unsigned DEFAULT_CNT_W = 32;

endpackage

// File: rtl/fwd_sel.sv
// Forwarding source selector for one operand.
//   src              : operand address read in EX
//   dest_mem, we_mem : MEM-stage destination address and write enable
//   dest_wb, we_wb   : WB-stage destination address and write enable
//   sel              : FWD_RF / FWD_MEM / FWD_WB, MEM taking priority
// EXCL_ZERO suppresses forwarding to address 0 (hard-wired x0); CSR
// instances clear it because CSR address 0 is a real register.
module fwd_sel
    import hazard_pkg::*;
#(
    parameter int unsigned AW        = 5,
    parameter bit          EXCL_ZERO = 1'b1
) (
    input  logic [AW-1:0] src,
    input  logic [AW-1:0] dest_mem,
    input  logic          we_mem,
    input  logic [AW-1:0] dest_wb,
    input  logic          we_wb,
    output logic [1:0]    sel
);

    logic hit_mem;
    logic hit_wb;

    assign hit_mem = we_mem && (dest_mem == src) && (!EXCL_ZERO || (dest_mem != '0));
    assign hit_wb  = we_wb  && (dest_wb  == src) && (!EXCL_ZERO || (dest_wb  != '0));

    always_comb begin
        sel = FWD_RF;
        if (hit_mem) begin
            sel = FWD_MEM;
        end else if (hit_wb) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the RV32I core.
//   clk, rst                     : core clock, synchronous active-high reset
//   reg*_src_ID, src*_used_ID    : ID-stage source addresses and their use flags
//   reg*_src_EX, reg_dest_EX     : ID/EX address register contents
//   csr_src_EX                   : CSR read address in EX
//   reg_dest_*/reg_write_en_*    : MEM/WB GPR destination state
//   csr_dest_*/csr_write_en_*    : MEM/WB CSR destination state
//   load_EX, br_EX, jalr_EX      : EX-stage load / redirect flags
//   jal_ID                       : jump resolved in ID
//   dcache_miss                  : level, high while the data cache refills
//   bubble*/flush*               : per-stage hold and squash controls
//   op1_sel, op2_sel, csr_fwd_sel: forwarding selects (FWD_RF/FWD_MEM/FWD_WB)
//   stall_cycles, flush_events   : saturating performance counters
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       reg1_src_ID,
    input  logic [4:0]       reg2_src_ID,
    input  logic [4:0]       reg1_src_EX,
    input  logic [4:0]       reg2_src_EX,
    input  logic [4:0]       reg_dest_EX,
    input  logic [11:0]      csr_src_EX,
    input  logic [4:0]       reg_dest_MEM,
    input  logic [4:0]       reg_dest_WB,
    input  logic             reg_write_en_MEM,
    input  logic             reg_write_en_WB,
    input  logic [11:0]      csr_dest_MEM,
    input  logic [11:0]      csr_dest_WB,
    input  logic             csr_write_en_MEM,
    input  logic             csr_write_en_WB,
    input  logic             load_EX,
    input  logic             src1_used_ID,
    input  logic             src2_used_ID,
    input  logic             br_EX,
    input  logic             jalr_EX,
    input  logic             jal_ID,
    input  logic             dcache_miss,
    output logic             bubbleF,
    output logic             bubbleD,
    output logic             bubbleE,
    output logic             bubbleM,
    output logic             bubbleW,
    output logic             flushF,
    output logic             flushD,
    output logic             flushE,
    output logic             flushM,
    output logic             flushW,
    output logic [1:0]       op1_sel,
    output logic [1:0]       op2_sel,
    output logic [1:0]       csr_fwd_sel,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    // Bit order in the stage vectors: [0]=F [1]=D [2]=E [3]=M [4]=W.
    localparam logic [4:0] STG_NONE  = 5'b00000;
    localparam logic [4:0] STG_ALL   = 5'b11111;
    localparam logic [4:0] STG_FD    = 5'b00011;
    localparam logic [4:0] STG_D     = 5'b00010;
    localparam logic [4:0] STG_E     = 5'b00100;
    localparam logic [4:0] STG_DE    = 5'b00110;
    localparam logic [4:0] STG_NOT_W = 5'b01111;

    state_e           state_q;
    logic [4:0]       bubble;
    logic [4:0]       flush;
    logic             redirect;
    logic             load_use;
    logic [1:0]       op1_raw;
    logic [1:0]       op2_raw;
    logic [1:0]       csr_raw;
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;

    // ---------------------------------------------------------------------
    // Forwarding
    // ---------------------------------------------------------------------
    fwd_sel #(
        .AW        (5),
        .EXCL_ZERO (1'b1)
    ) u_fwd_op1 (
        .src      (reg1_src_EX),
        .dest_mem (reg_dest_MEM),
        .we_mem   (reg_write_en_MEM),
        .dest_wb  (reg_dest_WB),
        .we_wb    (reg_write_en_WB),
        .sel      (op1_raw)
    );

    fwd_sel #(
        .AW        (5),
        .EXCL_ZERO (1'b1)
    ) u_fwd_op2 (
        .src      (reg2_src_EX),
        .dest_mem (reg_dest_MEM),
        .we_mem   (reg_write_en_MEM),
        .dest_wb  (reg_dest_WB),
        .we_wb    (reg_write_en_WB),
        .sel      (op2_raw)
    );

    fwd_sel #(
        .AW        (12),
        .EXCL_ZERO (1'b0)
    ) u_fwd_csr (
        .src      (csr_src_EX),
        .dest_mem (csr_dest_MEM),
        .we_mem   (csr_write_en_MEM),
        .dest_wb  (csr_dest_WB),
        .we_wb    (csr_write_en_WB),
        .sel      (csr_raw)
    );

    assign op1_sel     = rst ? FWD_RF : op1_raw;
    assign op2_sel     = rst ? FWD_RF : op2_raw;
    assign csr_fwd_sel = rst ? FWD_RF : csr_raw;

    // ---------------------------------------------------------------------
    // Stall FSM
    // ---------------------------------------------------------------------
    // Reset wins over a pending miss: the first post-reset cycle is always RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            unique case (state_q)
                RUN:        if (dcache_miss) state_q <= MISS_STALL;
                MISS_STALL: if (!dcache_miss) state_q <= MISS_DRAIN;
                MISS_DRAIN: state_q <= RUN;
                default:    state_q <= RUN;
            endcase
        end
    end

    assign redirect = br_EX || jalr_EX;

    assign load_use = load_EX && (reg_dest_EX != 5'd0) &&
                      (((reg_dest_EX == reg1_src_ID) && src1_used_ID) ||
                       ((reg_dest_EX == reg2_src_ID) && src2_used_ID));

    // Redirects are ignored outside RUN: EX is frozen during a miss, so the
    // branch is still present and gets acted on once RUN resumes.
    always_comb begin
        bubble = STG_NONE;
        flush  = STG_NONE;
        if (rst) begin
            flush = STG_ALL;
        end else begin
            case (state_q)
                MISS_STALL: bubble = STG_ALL;
                // WB retires the refilled load while the front stays held.
                MISS_DRAIN: bubble = STG_NOT_W;
                default: begin
                    if (redirect) begin
                        flush = STG_DE;
                    end else if (load_use) begin
                        bubble = STG_FD;
                        flush  = STG_E;
                    end else if (jal_ID) begin
                        flush = STG_D;
                    end
                end
            endcase
        end
    end

    assign bubbleF = bubble[0];
    assign bubbleD = bubble[1];
    assign bubbleE = bubble[2];
    assign bubbleM = bubble[3];
    assign bubbleW = bubble[4];
    assign flushF  = flush[0];
    assign flushD  = flush[1];
    assign flushE  = flush[2];
    assign flushM  = flush[3];
    assign flushW  = flush[4];

    // ---------------------------------------------------------------------
    // Saturating performance counters
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if ((|bubble) && (stall_q != '1)) begin
                stall_q <= stall_q + CNT_W'(1);
            end
            if ((flush[1] || flush[2]) && (flush_q != '1)) begin
                flush_q <= flush_q + CNT_W'(1);
            end
        end
    end

    assign stall_cycles = stall_q;
    assign flush_events = flush_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

    localparam int unsigned CW      = 8;
    localparam int          CNT_MAX = 255;
    localparam int          PH_RUN   = 0;
    localparam int          PH_STALL = 1;
    localparam int          PH_DRAIN = 2;

    typedef struct packed {
        logic [4:0]  r1_id;
        logic [4:0]  r2_id;
        logic [4:0]  r1_ex;
        logic [4:0]  r2_ex;
        logic [4:0]  rd_ex;
        logic [11:0] csr_ex;
        logic [4:0]  rd_mem;
        logic [4:0]  rd_wb;
        logic        we_mem;
        logic        we_wb;
        logic [11:0] csr_mem;
        logic [11:0] csr_wb;
        logic        csr_we_mem;
        logic        csr_we_wb;
        logic        load;
        logic        u1;
        logic        u2;
        logic        br;
        logic        jalr;
        logic        jal;
        logic        miss;
    } in_t;

    typedef struct {
        in_t        i;
        logic [4:0] b;
        logic [4:0] f;
        logic [1:0] s1;
        logic [1:0] s2;
        logic [1:0] sc;
    } vec_t;

    logic          clk;
    logic          rst;
    in_t           din;
    logic          bF, bD, bE, bM, bW;
    logic          fF, fD, fE, fM, fW;
    logic [1:0]    op1_sel, op2_sel, csr_fwd_sel;
    logic [CW-1:0] stall_cycles, flush_events;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int ph      = PH_RUN;
    int stall_m = 0;
    int flush_m = 0;

    hazard_ctrl #(
        .CNT_W (CW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .reg1_src_ID      (din.r1_id),
        .reg2_src_ID      (din.r2_id),
        .reg1_src_EX      (din.r1_ex),
        .reg2_src_EX      (din.r2_ex),
        .reg_dest_EX      (din.rd_ex),
        .csr_src_EX       (din.csr_ex),
        .reg_dest_MEM     (din.rd_mem),
        .reg_dest_WB      (din.rd_wb),
        .reg_write_en_MEM (din.we_mem),
        .reg_write_en_WB  (din.we_wb),
        .csr_dest_MEM     (din.csr_mem),
        .csr_dest_WB      (din.csr_wb),
        .csr_write_en_MEM (din.csr_we_mem),
        .csr_write_en_WB  (din.csr_we_wb),
        .load_EX          (din.load),
        .src1_used_ID     (din.u1),
        .src2_used_ID     (din.u2),
        .br_EX            (din.br),
        .jalr_EX          (din.jalr),
        .jal_ID           (din.jal),
        .dcache_miss      (din.miss),
        .bubbleF          (bF),
        .bubbleD          (bD),
        .bubbleE          (bE),
        .bubbleM          (bM),
        .bubbleW          (bW),
        .flushF           (fF),
        .flushD           (fD),
        .flushE           (fE),
        .flushM           (fM),
        .flushW           (fW),
        .op1_sel          (op1_sel),
        .op2_sel          (op2_sel),
        .csr_fwd_sel      (csr_fwd_sel),
        .stall_cycles     (stall_cycles),
        .flush_events     (flush_events)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    // Forwarding rule: MEM beats WB; optional exclusion of address 0.
    function automatic int fwd_m(input int src, input int dm, input bit wm,
                                 input int dw, input bit ww, input bit excl);
        if (wm && dm == src && !(excl && dm == 0)) return 1;
        if (ww && dw == src && !(excl && dw == 0)) return 2;
        return 0;
    endfunction

    task automatic model_out(input in_t i, input bit r, output int b, output int f,
                             output int s1, output int s2, output int sc);
        bit lu;
        b = 0; f = 0; s1 = 0; s2 = 0; sc = 0;
        if (r) begin
            f = 31;
            return;
        end
        s1 = fwd_m(int'(i.r1_ex), int'(i.rd_mem), i.we_mem, int'(i.rd_wb), i.we_wb, 1'b1);
        s2 = fwd_m(int'(i.r2_ex), int'(i.rd_mem), i.we_mem, int'(i.rd_wb), i.we_wb, 1'b1);
        sc = fwd_m(int'(i.csr_ex), int'(i.csr_mem), i.csr_we_mem,
                   int'(i.csr_wb), i.csr_we_wb, 1'b0);
        lu = i.load && i.rd_ex != 0 &&
             ((i.rd_ex == i.r1_id && i.u1) || (i.rd_ex == i.r2_id && i.u2));
        if (ph == PH_STALL) b = 31;
        else if (ph == PH_DRAIN) b = 15;           // all but WB
        else if (i.br || i.jalr) f = 6;            // D and E
        else if (lu) begin b = 3; f = 4; end       // hold F,D; squash E
        else if (i.jal) f = 2;
    endtask

    // One clock cycle: drive, check mid-cycle, advance the model at the edge.
    task automatic cycle(input in_t i, input bit r, input bit tbl, input vec_t v,
                         input string tag);
        int eb, ef, e1, e2, ec;
        din = i;
        rst = r;
        @(negedge clk);
        model_out(i, r, eb, ef, e1, e2, ec);
        if (tbl) begin
            eb = int'(v.b); ef = int'(v.f);
            e1 = int'(v.s1); e2 = int'(v.s2); ec = int'(v.sc);
        end
        chk({tag, "_bubble"}, int'({bW, bM, bE, bD, bF}), eb);
        chk({tag, "_flush"}, int'({fW, fM, fE, fD, fF}), ef);
        chk({tag, "_op1"}, int'(op1_sel), e1);
        chk({tag, "_op2"}, int'(op2_sel), e2);
        chk({tag, "_csr"}, int'(csr_fwd_sel), ec);
        chk({tag, "_stall_cnt"}, int'(stall_cycles), stall_m);
        chk({tag, "_flush_cnt"}, int'(flush_events), flush_m);
        @(posedge clk);
        if (r) begin
            ph = PH_RUN; stall_m = 0; flush_m = 0;
        end else begin
            if (eb != 0 && stall_m < CNT_MAX) stall_m++;
            if ((ef & 6) != 0 && flush_m < CNT_MAX) flush_m++;
            if (ph == PH_RUN && i.miss) ph = PH_STALL;
            else if (ph == PH_STALL && !i.miss) ph = PH_DRAIN;
            else if (ph == PH_DRAIN) ph = PH_RUN;
        end
        #1;
    endtask

    vec_t vt[14];
    vec_t nv;
    in_t  z;
    in_t  x;

    initial begin
        int snap_s, snap_f, mlen;
        z = '0;
        nv.i = '0; nv.b = '0; nv.f = '0; nv.s1 = '0; nv.s2 = '0; nv.sc = '0;
        for (int k = 0; k < 14; k++) vt[k] = nv;
        // forwarding
        vt[0].i.rd_mem = 5; vt[0].i.we_mem = 1; vt[0].i.rd_wb = 5; vt[0].i.we_wb = 1;
        vt[0].i.r1_ex = 5;  vt[0].s1 = 1;
        vt[1].i = vt[0].i;  vt[1].i.we_mem = 0; vt[1].s1 = 2;
        vt[2].i.we_mem = 1; vt[2].i.we_wb = 1;  vt[2].s1 = 0;
        vt[3].i.csr_wb = 12'h300; vt[3].i.csr_we_wb = 1; vt[3].i.csr_ex = 12'h300;
        vt[3].sc = 2;
        vt[4].i.csr_we_mem = 1; vt[4].sc = 1;   // CSR address 0 forwards
        vt[5].i.r2_ex = 9; vt[5].i.rd_wb = 9; vt[5].i.we_wb = 1; vt[5].i.rd_mem = 9;
        vt[5].s2 = 2;
        // load-use and redirects
        vt[6].i.load = 1; vt[6].i.rd_ex = 7; vt[6].i.r2_id = 7; vt[6].i.u2 = 1;
        vt[6].b = 5'b00011; vt[6].f = 5'b00100;
        vt[7].i = vt[6].i;  vt[7].i.u2 = 0;
        vt[8].i.load = 1;   vt[8].i.u1 = 1;     // rd_ex == 0 never stalls
        vt[9].i = vt[6].i;  vt[9].i.br = 1;     vt[9].f = 5'b00110;
        vt[10].i.jalr = 1;  vt[10].f = 5'b00110;
        vt[11].i.jal = 1;   vt[11].f = 5'b00010;
        vt[12].i = vt[6].i; vt[12].i.jal = 1;   vt[12].b = 5'b00011; vt[12].f = 5'b00100;
        vt[13].i.load = 1;  vt[13].i.rd_ex = 3; vt[13].i.r1_id = 3; vt[13].i.u1 = 1;
        vt[13].b = 5'b00011; vt[13].f = 5'b00100;

        din = z;
        rst = 1'b1;
        @(posedge clk);
        #1;
        cycle(z, 1'b1, 1'b0, nv, "reset");
        for (int k = 0; k < 14; k++) cycle(vt[k].i, 1'b0, 1'b1, vt[k], $sformatf("vec%0d", k));

        // Miss held 4 cycles with a branch waiting in EX.
        snap_s = stall_m; snap_f = flush_m;
        x = z; x.miss = 1;
        cycle(x, 1'b0, 1'b0, nv, "miss_rise");
        x.br = 1;
        for (int k = 0; k < 3; k++) cycle(x, 1'b0, 1'b0, nv, "miss_hold");
        x.miss = 0;
        cycle(x, 1'b0, 1'b0, nv, "miss_fall");
        cycle(x, 1'b0, 1'b0, nv, "miss_drain");
        cycle(x, 1'b0, 1'b0, nv, "miss_redirect");
        chk("miss_stall_delta", int'(stall_cycles), snap_s + 5);
        chk("miss_flush_delta", int'(flush_events), snap_f + 1);

        // Reset in the middle of a miss.
        x = z; x.miss = 1;
        for (int k = 0; k < 3; k++) cycle(x, 1'b0, 1'b0, nv, "rmiss_pre");
        cycle(x, 1'b1, 1'b0, nv, "rmiss_rst");
        cycle(x, 1'b1, 1'b0, nv, "rmiss_rst");
        chk("rmiss_stall_zero", int'(stall_cycles), 0);
        x.br = 1;
        cycle(x, 1'b0, 1'b0, nv, "rmiss_first_run");
        x.br = 0;
        cycle(x, 1'b0, 1'b0, nv, "rmiss_restall");
        x.miss = 0;
        cycle(x, 1'b0, 1'b0, nv, "rmiss_exit");
        cycle(x, 1'b0, 1'b0, nv, "rmiss_drain");

        // Saturate stall_cycles with a long miss.
        cycle(z, 1'b1, 1'b0, nv, "sat_rst");
        x = z; x.miss = 1;
        for (int k = 0; k < 262; k++) cycle(x, 1'b0, 1'b0, nv, "sat");
        chk("sat_at_max", int'(stall_cycles), CNT_MAX);
        cycle(x, 1'b0, 1'b0, nv, "sat_more");
        chk("sat_hold", int'(stall_cycles), CNT_MAX);
        x.miss = 0;
        cycle(x, 1'b0, 1'b0, nv, "sat_exit");
        cycle(x, 1'b0, 1'b0, nv, "sat_drain");

        // Randomised traffic against the model.
        cycle(z, 1'b1, 1'b0, nv, "rnd_rst");
        mlen = 0;
        for (int k = 0; k < 500; k++) begin
            bit r;
            x.r1_id = 5'($urandom_range(0, 7));  x.r2_id = 5'($urandom_range(0, 7));
            x.r1_ex = 5'($urandom_range(0, 7));  x.r2_ex = 5'($urandom_range(0, 7));
            x.rd_ex = 5'($urandom_range(0, 7));  x.rd_mem = 5'($urandom_range(0, 7));
            x.rd_wb = 5'($urandom_range(0, 7));
            x.we_mem = 1'($urandom_range(0, 1)); x.we_wb = 1'($urandom_range(0, 1));
            x.csr_ex  = ($urandom_range(0, 1) == 1) ? 12'h300 : 12'h000;
            x.csr_mem = ($urandom_range(0, 1) == 1) ? 12'h300 : 12'h000;
            x.csr_wb  = ($urandom_range(0, 1) == 1) ? 12'h300 : 12'h000;
            x.csr_we_mem = 1'($urandom_range(0, 1)); x.csr_we_wb = 1'($urandom_range(0, 1));
            x.load = 1'($urandom_range(0, 1));
            x.u1 = 1'($urandom_range(0, 1));     x.u2 = 1'($urandom_range(0, 1));
            x.br   = ($urandom_range(0, 7) == 0);
            x.jalr = ($urandom_range(0, 7) == 0);
            x.jal  = ($urandom_range(0, 3) == 0);
            if (mlen == 0 && $urandom_range(0, 19) == 0) mlen = $urandom_range(1, 6);
            x.miss = (mlen > 0);
            if (mlen > 0) mlen--;
            r = ($urandom_range(0, 63) == 0);
            cycle(x, r, 1'b0, nv, "rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
